lock_input_frontend: RTL
========================

# lock_input_frontend

Input conditioning stage that sits directly upstream of the lock controller FSM (WAIT/INPUT/UNLOCK/ERROR/ALARM). It synchronises and debounces the 10 slide switches and 3 push buttons. Each switch toggle becomes a digit event (digit = switch index), delivered over a valid/ready handshake. Each button press becomes a single-cycle command pulse. The controller therefore consumes clean events and never compares raw levels against history itself.

## Interface
Parameters:
- DB_CNT, 1_000_000: debounce sample period in CLK cycles (10 ms at 100 MHz); must be ≥ 2.
- DB_W, 20: prescaler counter width; requires 2^DB_W > DB_CNT.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- SW  in  10  raw slide switches, asynchronous to CLK.
- BTN  in  3  raw buttons: [0] ADMIN, [1] OK, [2] BACKSPACE.
- DIGIT_READY  in  1  controller accepts the current digit.
- DIGIT_VALID  out  1  digit event pending on DIGIT.
- DIGIT  out  4  digit value 0–9; 0 whenever DIGIT_VALID=0.
- ADMIN_P  out  1  one-cycle pulse per ADMIN press.
- OK_P  out  1  one-cycle pulse per OK press.
- BKSP_P  out  1  one-cycle pulse per BACKSPACE press.
- OVERRUN_P  out  1  one-cycle pulse when a toggle is dropped.

## Operation
- Reset: all outputs 0, pending mask 0, prescaler 0, warm-up active.
- Synchroniser: two-flop chain on all 13 inputs (s0, s1).
- Debounce (macro on): a shared prescaler produces a tick every DB_CNT cycles. On each tick every input is sampled into smp. When s1 equals smp at the tick, the stable register takes that value. An input must therefore hold for two consecutive ticks to be accepted.
- Warm-up: after reset release, the first update of the stable registers loads the baseline only and generates no events. Switches that are already ON at reset therefore do not create digits.
- Switch toggle: any change of stable SW[i], in either direction, sets pending[i].
- Pending bit already set when its switch toggles again: the toggle is dropped, OVERRUN_P pulses, and pending[i] stays 1.
- Digit output: when DIGIT_VALID=0 and pending≠0, the lowest set index is loaded into DIGIT and DIGIT_VALID is raised in the next cycle.
- DIGIT and DIGIT_VALID stay stable until DIGIT_VALID & DIGIT_READY. In that cycle the presented pending bit clears and DIGIT_VALID drops for at least one cycle.
- Accept and a new toggle of the same switch in the same cycle: the set wins, the bit stays pending, no OVERRUN.
- Buttons: a rising edge of stable BTN produces a pulse. Simultaneous edges are prioritised ADMIN > OK > BKSP; only the winner pulses and the rest are discarded. Falling edges are ignored.
- Button pulses are independent of the digit handshake and may coincide with DIGIT_VALID.

## Timing
- Macro off: SW change present at edge N gives DIGIT_VALID high after edge N+4 (sync 2, stable 1, pending 1), provided nothing is pending.
- Macro off: BTN rise at edge N gives the pulse high for exactly one cycle after edge N+3.
- Macro on: latency is between DB_CNT+3 and 2·DB_CNT+4 cycles. Glitches shorter than DB_CNT are always rejected.
- Back-to-back digits: at most one digit per 2 cycles with DIGIT_READY tied high.
- RESET mid-handshake: DIGIT_VALID drops immediately (asynchronous). Pending events are lost and warm-up reruns.

## Configuration
- LOCK_FE_DEBOUNCE_EN defined: the prescaler/tick debounce is built as described above.
- LOCK_FE_DEBOUNCE_EN undefined: the prescaler and smp registers are removed. The stable registers load s1 every cycle and warm-up is the first cycle after reset release. Intended for fast simulation.
- Handshake, priority and overrun behaviour are identical in both builds.

## Test plan
- Macro off, SW held 10'h004 through reset, then released → no digit event; then SW[2] toggles to 0 → DIGIT=2, DIGIT_VALID high 4 cycles after the change.
- Macro off, DIGIT_READY=0, toggle SW[7] then SW[1] → DIGIT=7 held; raise READY → accept 7, then DIGIT=1 two cycles later.
- Macro off, READY=0, toggle SW[3] twice → single OVERRUN_P pulse; exactly one digit 3 delivered after READY.
- Macro off, BTN 3'b011 rises simultaneously → only ADMIN_P pulses, for one cycle; OK_P stays 0; holding BTN produces no repeat.
- Macro on, DB_CNT=4: 3-cycle pulse on BTN[1] → no OK_P; 12-cycle hold → exactly one OK_P.
- RESET asserted while DIGIT_VALID=1 with pending=10'h0A0 → all outputs 0 the same cycle; after release no events until the next switch toggle.

Source files
------------

// File: rtl/lock_input_frontend.sv
// lock_input_frontend
//
// Conditions the raw slide switches and push buttons for the lock controller.
// All 13 inputs are synchronised with two flops and then pass through a
// "stable" register. Each change of a stable switch marks that switch as
// pending. Pending switches are presented one at a time, lowest index first,
// as digit events. Each rising edge of a stable button produces a one-cycle
// command pulse.
//
// Optional feature: define LOCK_FE_DEBOUNCE_EN to build the prescaler/tick
// debouncer. With the macro undefined, the stable registers follow the
// synchroniser every cycle. Use that build for fast simulation.
//
// Digit handshake: DIGIT/DIGIT_VALID are held stable until a cycle in which
// DIGIT_VALID and DIGIT_READY are both high. That cycle is the transfer.
// After a transfer, DIGIT_VALID is low for at least one cycle.
//
// Ports:
//   CLK          system clock
//   RESET        asynchronous, active-high reset
//   SW[9:0]      raw slide switches (asynchronous to CLK)
//   BTN[2:0]     raw buttons: [0] ADMIN, [1] OK, [2] BACKSPACE
//   DIGIT_READY  controller accepts the presented digit
//   DIGIT_VALID  a digit event is presented on DIGIT
//   DIGIT[3:0]   switch index 0..9, forced to 0 while DIGIT_VALID is low
//   ADMIN_P      one-cycle pulse per ADMIN press
//   OK_P         one-cycle pulse per OK press
//   BKSP_P       one-cycle pulse per BACKSPACE press
//   OVERRUN_P    one-cycle pulse when a switch toggle is dropped
//
// Parameters:
//   DB_CNT  debounce sample period in CLK cycles (>= 2)
//   DB_W    prescaler width, 2**DB_W > DB_CNT

module lock_input_frontend #(
    parameter int DB_CNT = 1_000_000,
    parameter int DB_W   = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] SW,
    input  logic [2:0] BTN,
    input  logic       DIGIT_READY,
    output logic       DIGIT_VALID,
    output logic [3:0] DIGIT,
    output logic       ADMIN_P,
    output logic       OK_P,
    output logic       BKSP_P,
    output logic       OVERRUN_P
);

    typedef enum logic {
        ST_IDLE,
        ST_SHOW
    } state_t;

    logic [12:0] raw;
    logic [12:0] s0, s1;
    logic [12:0] stb, stb_n;
    logic [12:0] chg;
    logic        warm;
    logic        upd;
    logic [12:0] acc;

    assign raw = {BTN, SW};

    // The synchroniser has no reset. This lets inputs that are held through
    // reset already be present when warm-up captures the baseline.
    always_ff @(posedge CLK) begin
        s0 <= raw;
        s1 <= s0;
    end

`ifdef LOCK_FE_DEBOUNCE_EN
    logic [DB_W-1:0] pre;
    logic            tick;
    logic [12:0]     smp;

    assign tick = (pre == DB_W'(DB_CNT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + DB_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            smp <= '0;
        end else if (tick) begin
            smp <= s1;
        end
    end

    // An input is accepted only if it matched at two consecutive ticks.
    // During warm-up, every bit loads unconditionally to form the baseline.
    assign upd = tick;
    assign acc = warm ? '1 : ~(s1 ^ smp);
`else
    // The debounce parameters have no effect in this build.
    logic [DB_W-1:0] unused_db;
    assign unused_db = DB_W'(DB_CNT);

    assign upd = 1'b1;
    assign acc = '1;
`endif

    assign stb_n = upd ? ((stb & ~acc) | (s1 & acc)) : stb;

    // chg records which stable bits changed on the last update.
    // It stays 0 for the warm-up load, so levels present at reset never
    // produce events.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stb  <= '0;
            chg  <= '0;
            warm <= 1'b1;
        end else begin
            chg <= (upd && !warm) ? (stb_n ^ stb) : '0;
            stb <= stb_n;
            if (upd) begin
                warm <= 1'b0;
            end
        end
    end

    // Buttons: rising edges only. Simultaneous presses are resolved in the
    // order ADMIN > OK > BKSP; the losing presses are discarded.
    logic [2:0] rise;
    assign rise = chg[12:10] & stb[12:10];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ADMIN_P <= 1'b0;
            OK_P    <= 1'b0;
            BKSP_P  <= 1'b0;
        end else begin
            ADMIN_P <= rise[0];
            OK_P    <= rise[1] & ~rise[0];
            BKSP_P  <= rise[2] & ~rise[1] & ~rise[0];
        end
    end

    // Digit presenter
    function automatic logic [3:0] low_idx(input logic [9:0] m);
        low_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (m[i]) begin
                low_idx = 4'(i);
            end
        end
    endfunction

    state_t     st, st_n;
    logic [9:0] pending, pending_n;
    logic [9:0] tog, clr;
    logic [3:0] digit_n;
    logic       ovr_n;

    assign tog = chg[9:0];

    always_comb begin
        st_n    = st;
        digit_n = DIGIT;
        clr     = '0;
        case (st)
            ST_IDLE: begin
                if (|pending) begin
                    st_n    = ST_SHOW;
                    digit_n = low_idx(pending);
                end
            end
            ST_SHOW: begin
                if (DIGIT_READY) begin
                    st_n    = ST_IDLE;
                    digit_n = 4'd0;
                    clr     = 10'b1 << DIGIT;
                end
            end
            default: begin
                st_n    = ST_IDLE;
                digit_n = 4'd0;
            end
        endcase
        // When a set and a clear hit the same bit, the set wins. A toggle of
        // a switch that is still pending is dropped and reported.
        pending_n = (pending & ~clr) | tog;
        ovr_n     = |(tog & pending & ~clr);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st        <= ST_IDLE;
            DIGIT     <= 4'd0;
            pending   <= '0;
            OVERRUN_P <= 1'b0;
        end else begin
            st        <= st_n;
            DIGIT     <= digit_n;
            pending   <= pending_n;
            OVERRUN_P <= ovr_n;
        end
    end

    assign DIGIT_VALID = (st == ST_SHOW);

endmodule
